fpadd_result_display_seq: RTL
=============================

// Module: fpadd_result_display_seq
// PURPOSE
//  Streaming front-end/back-end for the pipelined FP adder on the board.
//  - Accepts operand pairs over a valid/ready handshake and drives them into an external fixed-latency adder.
//  - Tracks operations in flight and captures each result into a DEPTH-entry result FIFO.
//  - Presents the FIFO head on the LEDs and on NUM_DISP 8-bit chars for the seven-segment display drivers.
//  - User pulses page through the head result or pop it, replacing constant-operand, single-result display.
// PARAMETERS
//  WIDTH        32  operand/result width; must be a multiple of 8*NUM_DISP
//  DEPTH        8   result FIFO entries; power of two, >=2
//  ADD_LATENCY  3   adder latency (cycles from add_a/add_b to add_result); >=1
//  NUM_DISP     2   number of 8-bit display chars; PAGES = WIDTH/(8*NUM_DISP)
// PORTS
//  clk         in   1                 system clock, all state on rising edge
//  rst         in   1                 async active-high reset
//  in_valid    in   1                 operand pair valid
//  in_ready    out  1                 block can accept a pair
//  in_a        in   WIDTH             operand A
//  in_b        in   WIDTH             operand B
//  add_a       out  WIDTH             registered operand A to adder
//  add_b       out  WIDTH             registered operand B to adder
//  add_result  in   WIDTH             adder output
//  next_pulse  in   1                 1-cycle (debounced) request: pop FIFO head
//  page_pulse  in   1                 1-cycle (debounced) request: advance display page
//  leds        out  8                 head[7:0]
//  disp_chars  out  8*NUM_DISP        page bytes; MS byte -> display 0
//  count       out  $clog2(DEPTH+1)   stored results
//  empty       out  1                 count==0
//  full        out  1                 count==DEPTH
// BEHAVIOUR
//  Reset values (async, on rst=1)
//   - add_a/add_b=0, inflight valid shift reg=0, FIFO ptrs/count=0, page=0.
//   - Resulting outputs: empty=1, full=0, in_ready=1, leds=0, disp_chars=0.
//  Issue path
//   - Accept on in_valid&&in_ready at edge t; add_a/add_b<=in_a/in_b, visible cycle t+1.
//   - add_a/add_b hold their last value when no accept.
//  Capture path
//   - Valid bit enters ADD_LATENCY-deep shift reg at the accept edge.
//   - add_result is sampled into FIFO tail at edge t+1+ADD_LATENCY.
//   - Result is visible at head/leds no earlier than cycle t+2+ADD_LATENCY.
//   - One result per cycle max; capture order == accept order.
//  Credit flow control
//   - in_ready = (count + inflight_cnt) < DEPTH, from registers only.
//   - Capture never finds FIFO full; no result is ever dropped.
//   - in_ready does not depend on in_valid.
//  Pop
//   - next_pulse&&!empty: advance head, count-1, page<=0.
//   - next_pulse while empty: ignored.
//   - Capture and pop in same cycle: both happen, count unchanged.
//  Page
//   - page_pulse: page<=page+1, wraps PAGES-1 -> 0.
//   - next_pulse and page_pulse together: pop wins, page=0.
//  Display
//   - disp_chars = head[WIDTH-1-page*8*NUM_DISP -: 8*NUM_DISP] when !empty.
//   - leds = head[7:0] when !empty.
//   - When empty, leds=0 and disp_chars=0.
//  Reset mid-operation
//   - In-flight ops and stored results are discarded.
//   - Stale add_result after reset is ignored, since valid bits are cleared.
// TESTING (stub adder: latency ADD_LATENCY, result=a^b)
//  1 Reset: rst pulse -> in_ready=1, empty=1, count=0, leds=0, disp_chars=0.
//  2 Single op: A=32'h2ac49214, B=32'h6ac49214 accepted at t -> head=32'h40000000 first at t+5.
//    Also: leds=8'h00, disp_chars=16'h4000.
//  3 Fill: in_valid held high, no pops -> exactly 8 accepts, then in_ready=0.
//    Then full=1, count=8; pops return the 8 results in order.
//  4 Paging: head=32'h12345678 -> disp 16'h1234; page_pulse -> 16'h5678; page_pulse -> 16'h1234.
//  5 Simultaneous: capture + next_pulse same cycle with count=3 -> count stays 3, order kept, page=0.
//  6 Reset mid-op: 2 ops in flight, rst 1 cycle -> no capture after release, empty=1.

Source files
------------

// File: rtl/fpadd_result_display_seq.sv
// fpadd_result_display_seq: issues operand pairs to a fixed-latency adder, queues results, displays the queue head
module fpadd_result_display_seq #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 8,
  parameter int ADD_LATENCY = 3,
  parameter int NUM_DISP    = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_a,
  input  logic [WIDTH-1:0]             in_b,
  output logic [WIDTH-1:0]             add_a,
  output logic [WIDTH-1:0]             add_b,
  input  logic [WIDTH-1:0]             add_result,
  input  logic                         next_pulse,
  input  logic                         page_pulse,
  output logic [7:0]                   leds,
  output logic [8*NUM_DISP-1:0]        disp_chars,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);
  localparam int DW    = 8 * NUM_DISP;
  localparam int PAGES = WIDTH / DW;
  localparam int PW    = PAGES > 1 ? $clog2(PAGES) : 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  // pipe[0] marks the operand register stage, pipe[ADD_LATENCY] marks a result ready to capture
  logic [ADD_LATENCY:0] pipe;
  logic [WIDTH-1:0]     mem [DEPTH];
  logic [WIDTH-1:0]     head;
  logic [AW-1:0]        wp, rp;
  logic [PW-1:0]        page;
  logic [31:0]          occ;
  logic                 accept, cap, pop;
  // Credits: stored results plus every op still travelling through the adder
  always_comb begin
    occ = 32'(count);
    for (int i = 0; i <= ADD_LATENCY; i++) occ = occ + 32'(pipe[i]);
  end
  assign in_ready   = occ < 32'(DEPTH);
  assign accept     = in_valid && in_ready;
  assign cap        = pipe[ADD_LATENCY];
  assign pop        = next_pulse && !empty;
  assign empty      = count == '0;
  assign full       = count == CW'(DEPTH);
  assign head       = mem[rp];
  assign leds       = empty ? 8'h00 : head[7:0];
  assign disp_chars = empty ? '0 : head[WIDTH-1-int'(page)*DW -: DW];
  // Operand registers feeding the adder hold their value between accepts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_a <= '0;
      add_b <= '0;
    end else if (accept) begin
      add_a <= in_a;
      add_b <= in_b;
    end
  end
  // Valid bits track each accepted op until its result is captured
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pipe <= '0;
    else     pipe <= {pipe[ADD_LATENCY-1:0], accept};
  end
  // Result storage; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (cap) mem[wp] <= add_result;
  end
  // FIFO pointers and occupancy; capture and pop may coincide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= wp + AW'(cap);
      rp    <= rp + AW'(pop);
      count <= count + CW'(cap) - CW'(pop);
    end
  end
  // Display page: a pop always returns to the most significant page
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             page <= '0;
    else if (pop)        page <= '0;
    else if (page_pulse) page <= page == PW'(PAGES - 1) ? '0 : page + 1'b1;
  end
endmodule
